// File: rtl/med_ctrl.sv
// Control sequencer for the serial median unit: loads an N_PIXELS window, runs K sort passes, flags the median.
// DSO N*(K+1)+N-1-K cycles after the first load cycle; no stall input, so overruns are dropped and flagged on ERR.
module med_ctrl #(
  parameter int N_PIXELS = 9
) (
  input  logic CLK,
  input  logic RST,
  input  logic DSI_IN,
  output logic DSI,
  output logic BYP,
  output logic DSO,
  output logic BUSY,
  output logic ERR
);

  localparam int K  = (N_PIXELS - 1) / 2;
  localparam int CW = $clog2(N_PIXELS + 1);

  localparam logic [CW-1:0] LOAD_LAST  = CW'(N_PIXELS - 1);
  localparam logic [CW-1:0] FINAL_LAST = CW'(N_PIXELS - 2 - K);
  localparam logic [CW-1:0] PASS_LAST  = CW'(K - 1);
  localparam logic [CW-1:0] CMP_BASE   = CW'(N_PIXELS - 2);

  typedef enum logic [2:0] {IDLE, LOAD, CMP, BYPS, FINAL, DONE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] pass;
  logic [CW-1:0] cmp_last;
  logic          err_q;

  // Each compare phase shrinks by one cycle per pass as the sorted tail grows.
  assign cmp_last = CMP_BASE - pass;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      cnt   <= '0;
      pass  <= '0;
      err_q <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state)
        IDLE: begin
          if (DSI_IN) begin
            state <= LOAD;
            cnt   <= CW'(1);
          end
        end
        LOAD: begin
          if (!DSI_IN) begin
            err_q <= 1'b1;
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == LOAD_LAST) begin
            state <= CMP;
            cnt   <= '0;
            pass  <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        CMP: begin
          err_q <= DSI_IN;
          if (cnt == cmp_last) begin
            state <= BYPS;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        BYPS: begin
          err_q <= DSI_IN;
          if (cnt == pass) begin
            cnt <= '0;
            if (pass == PASS_LAST) begin
              state <= FINAL;
            end else begin
              state <= CMP;
              pass  <= pass + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        FINAL: begin
          err_q <= DSI_IN;
          if (cnt == FINAL_LAST) begin
            state <= DONE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          // The DSO cycle doubles as load cycle 1 of a back-to-back window.
          if (DSI_IN) begin
            state <= LOAD;
            cnt   <= CW'(1);
          end else begin
            state <= IDLE;
            cnt   <= '0;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          pass  <= '0;
        end
      endcase
    end
  end

  assign DSI  = DSI_IN & ((state == IDLE) | (state == LOAD) | (state == DONE));
  assign BYP  = !((state == CMP) | (state == FINAL));
  assign DSO  = (state == DONE);
  assign BUSY = (state != IDLE) | DSI_IN;
  assign ERR  = err_q;

endmodule

// File: tb/tb_med_ctrl.sv
// Directed bench for med_ctrl (N_PIXELS=9): single, back-to-back, load gap, overrun and reset mid-sort.
module tb_med_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic dsi_in;
  logic dsi, byp, dso, busy, err;

  int n_assert = 0;
  int n_fail   = 0;

  med_ctrl #(.N_PIXELS(9)) dut (
    .CLK   (clk),
    .RST   (rst),
    .DSI_IN(dsi_in),
    .DSI   (dsi),
    .BYP   (byp),
    .DSO   (dso),
    .BUSY  (busy),
    .ERR   (err)
  );

  always #5 clk = ~clk;

  // BYP low windows for one N=9 window, cycle 0 = first load cycle.
  function automatic logic byp_exp(input int u);
    if ((u >= 9 && u <= 16) || (u >= 18 && u <= 24) || (u >= 27 && u <= 32) ||
        (u >= 36 && u <= 40) || (u >= 45 && u <= 48))
      return 1'b0;
    return 1'b1;
  endfunction

  // Apply inputs just after the rising edge, then sample at the falling edge.
  task automatic step(input logic r, input logic d);
    @(posedge clk);
    #1;
    rst    = r;
    dsi_in = d;
    #4;
  endtask

  task automatic chk(input string tag, input int t, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cycle %0d: observed %b expected %b", tag, t, obs, exp);
    end
  endtask

  task automatic chk_all(input int t, input logic e_dsi, input logic e_byp,
                         input logic e_dso, input logic e_busy, input logic e_err);
    chk("dsi",  t, dsi,  e_dsi);
    chk("byp",  t, byp,  e_byp);
    chk("dso",  t, dso,  e_dso);
    chk("busy", t, busy, e_busy);
    chk("err",  t, err,  e_err);
  endtask

  task automatic idle_gap(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0);
  endtask

  initial begin
    rst    = 1'b1;
    dsi_in = 1'b0;

    // Reset state
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    chk_all(-1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle_gap(2);

    // Single window
    for (int t = 0; t <= 52; t++) begin
      step(1'b0, t <= 8);
      chk_all(t, t <= 8, byp_exp(t), t == 49, t <= 49, 1'b0);
    end
    idle_gap(3);

    // Back-to-back windows, second starting in the DSO cycle
    for (int t = 0; t <= 100; t++) begin
      logic d;
      d = (t <= 8) || (t >= 49 && t <= 57);
      step(1'b0, d);
      chk_all(t, d, (t < 98) ? byp_exp(t % 49) : 1'b1, (t == 49) || (t == 98), t <= 98, 1'b0);
    end
    idle_gap(3);

    // Load gap on cycle 5
    for (int t = 0; t <= 10; t++) begin
      step(1'b0, t <= 4);
      chk_all(t, t <= 4, 1'b1, 1'b0, t <= 5, t == 6);
    end
    idle_gap(3);

    // Overrun pulse on cycle 20
    for (int t = 0; t <= 52; t++) begin
      step(1'b0, (t <= 8) || (t == 20));
      chk_all(t, t <= 8, byp_exp(t), t == 49, t <= 49, t == 21);
    end
    idle_gap(3);

    // Reset on cycle 30, new window from cycle 40
    for (int t = 0; t <= 92; t++) begin
      logic d;
      d = (t <= 8) || (t >= 40 && t <= 48);
      step(t == 30, d);
      if (t <= 30)
        chk_all(t, d, byp_exp(t), 1'b0, 1'b1, 1'b0);
      else if (t < 40)
        chk_all(t, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      else
        chk_all(t, d, byp_exp(t - 40), t == 89, t <= 89, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
